// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_timing_pkg : default 640x480@60 raster constants and helpers        |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package vga_timing_pkg;

   typedef logic [9:0] coord_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_FC_W     = 8;
   localparam int MAX_TOTAL    = 1024;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_mod_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mod_counter : modulo-N counter with enable, sync reset and wrap flag   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module mod_counter #(
   parameter int N = 800,
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic [W-1:0] o_count_next,
   output logic         o_wrap
);

   localparam logic [W-1:0] c_last = W'(N - 1);

   // o_count_next is exposed so the parent can register decodes in step with the count
   always_comb begin
      o_wrap       = i_en && (o_count == c_last);
      o_count_next = o_count;
      if (i_en)
         o_count_next = o_wrap ? '0 : o_count + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         o_count <= '0;
      else
         o_count <= o_count_next;
   end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_timing_gen : raster counters, sync/blank decode, frame pulse/count |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int FC_W     = DEF_FC_W
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            pix_en,
   output logic [9:0]      DrawX,
   output logic [9:0]      DrawY,
   output logic            hs,
   output logic            vs,
   output logic            active_nblank,
   output logic            frame_start,
   output logic [FC_W-1:0] frame_count
);

   localparam int c_h_total = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int c_v_total = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // 11-bit bounds so a window ending exactly at 1024 still compares correctly
   localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] c_h_act    = 11'(H_ACTIVE);
   localparam logic [10:0] c_v_act    = 11'(V_ACTIVE);

   generate
      if (c_h_total > MAX_TOTAL || c_v_total > MAX_TOTAL) begin : g_total_check
         $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 1024");
      end
   endgenerate

   coord_t w_x_next;
   coord_t w_y_next;
   logic   w_h_wrap;
   logic   w_v_wrap;
   logic   w_v_en;
   logic   w_hs_next;
   logic   w_vs_next;
   logic   w_act_next;

   assign w_v_en = pix_en & w_h_wrap;

   mod_counter #(.N(c_h_total), .W(10)) u_hcnt (
      .clk          (Clk),
      .rst          (Reset),
      .i_en         (pix_en),
      .o_count      (DrawX),
      .o_count_next (w_x_next),
      .o_wrap       (w_h_wrap)
   );

   mod_counter #(.N(c_v_total), .W(10)) u_vcnt (
      .clk          (Clk),
      .rst          (Reset),
      .i_en         (w_v_en),
      .o_count      (DrawY),
      .o_count_next (w_y_next),
      .o_wrap       (w_v_wrap)
   );

   // Decoding the next counts keeps sync/blank aligned with DrawX/DrawY after the edge
   always_comb begin
      w_hs_next  = !(({1'b0, w_x_next} >= c_hs_start) && ({1'b0, w_x_next} < c_hs_end));
      w_vs_next  = !(({1'b0, w_y_next} >= c_vs_start) && ({1'b0, w_y_next} < c_vs_end));
      w_act_next = ({1'b0, w_x_next} < c_h_act) && ({1'b0, w_y_next} < c_v_act);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hs            <= 1'b1;
         vs            <= 1'b1;
         active_nblank <= 1'b1;
         frame_start   <= 1'b0;
         frame_count   <= '0;
      end else begin
         hs            <= w_hs_next;
         vs            <= w_vs_next;
         active_nblank <= w_act_next;
         frame_start   <= w_v_wrap;
         if (w_v_wrap)
            frame_count <= frame_count + FC_W'(1);
      end
   end

endmodule
`default_nettype wire
